// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//
// Two-requester APB master with a round-robin arbiter. It serialises single
// read/write commands from the host register port (req0) and the UART bridge
// (req1) onto an 8-bit data / 4-bit address APB bus. Each transfer runs
// IDLE -> SETUP -> ACCESS. ACCESS waits on PREADY with a cycle timeout. The
// result is returned to the requester that owns the transfer as a one-cycle
// response pulse.
//
// Ports
//   PCLK, PRESETn            clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata   command from requester N (held until accepted)
//   reqN_ready               combinational accept (IDLE arbitration winner)
//   respN_valid/rdata/err    registered one-cycle response to requester N
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY   APB bus
//   busy                     high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module apb_rr_master #(
  parameter int TIMEOUT = 16,  // max ACCESS cycles without PREADY, 2..255
  parameter int CNT_W   = 8    // wait counter width, 2**CNT_W > TIMEOUT
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  // requester 0
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       resp0_valid,
  output logic [7:0] resp0_rdata,
  output logic       resp0_err,
  // requester 1
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       resp1_valid,
  output logic [7:0] resp1_rdata,
  output logic       resp1_err,
  // APB
  output logic       PSELx,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [3:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  // status
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;     // requester that wins when both are valid
  logic             owner_q, owner_d;   // requester that owns the transfer
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwrite_q, pwrite_d;
  logic [3:0]       paddr_q, paddr_d;
  logic [7:0]       pwdata_q, pwdata_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic [7:0]       resp0_rdata_q, resp0_rdata_d;
  logic             resp0_err_q, resp0_err_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic [7:0]       resp1_rdata_q, resp1_rdata_d;
  logic             resp1_err_q, resp1_err_d;

  logic             win1;      // requester 1 is the IDLE arbitration winner
  logic             any_req;
  logic             done;      // transfer completes on this edge
  logic             done_ok;   // ... with PREADY (not a timeout)
  logic [7:0]       done_data;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    resp0_valid_d = 1'b0;
    resp0_rdata_d = resp0_rdata_q;
    resp0_err_d   = resp0_err_q;
    resp1_valid_d = 1'b0;
    resp1_rdata_d = resp1_rdata_q;
    resp1_err_d   = resp1_err_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    done          = 1'b0;
    done_ok       = 1'b0;

    // Requester 1 wins if it is alone, or if both ask and it holds priority.
    win1    = req1_valid && (!req0_valid || prio_q);
    any_req = req0_valid || req1_valid;

    unique case (state_q)
      IDLE: begin
        // Gated by PRESETn so ready stays low while reset is applied.
        req0_ready = PRESETn && req0_valid && !win1;
        req1_ready = PRESETn && win1;
        if (any_req) begin
          owner_d  = win1;
          prio_d   = !win1;  // the other requester wins the next tie
          pwrite_d = win1 ? req1_write : req0_write;
          paddr_d  = win1 ? req1_addr  : req0_addr;
          pwdata_d = win1 ? req1_wdata : req0_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // PREADY is deliberately ignored here.
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          done    = 1'b1;
          done_ok = 1'b1;
        end else if (cnt_q == CntLast) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Writes and timeouts both return zero data.
    done_data = (done_ok && !pwrite_q) ? PRDATA : 8'h00;
    if (done) begin
      if (owner_q) begin
        resp1_valid_d = 1'b1;
        resp1_rdata_d = done_data;
        resp1_err_d   = !done_ok;
      end else begin
        resp0_valid_d = 1'b1;
        resp0_rdata_d = done_data;
        resp0_err_d   = !done_ok;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      resp0_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp0_err_q   <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp1_rdata_q <= '0;
      resp1_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      resp0_valid_q <= resp0_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp0_err_q   <= resp0_err_d;
      resp1_valid_q <= resp1_valid_d;
      resp1_rdata_q <= resp1_rdata_d;
      resp1_err_q   <= resp1_err_d;
    end
  end

  // Bus controls follow the registered state, so they drop on the same edge
  // that completes the transfer or applies reset.
  assign PSELx       = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign busy        = (state_q != IDLE);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign resp0_valid = resp0_valid_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp0_err   = resp0_err_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_rdata = resp1_rdata_q;
  assign resp1_err   = resp1_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_master
//
// Directed bench for apb_rr_master (TIMEOUT=16). Inputs change and outputs are
// sampled around the falling edge of PCLK; the slave side (PREADY/PRDATA) is
// driven per ACCESS cycle by the bench.
// ---------------------------------------------------------------------------
module tb_apb_rr_master;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       req0_valid, req0_write, req0_ready;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       resp0_valid, resp0_err;
  logic [7:0] resp0_rdata;
  logic       req1_valid, req1_write, req1_ready;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       resp1_valid, resp1_err;
  logic [7:0] resp1_rdata;
  logic       PSELx, PENABLE, PWRITE, PREADY, busy;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  int n_tests = 0;
  int n_fail  = 0;

  apb_rr_master #(.TIMEOUT(16), .CNT_W(8)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req0_valid (req0_valid),
    .req0_write (req0_write),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata),
    .resp0_err  (resp0_err),
    .req1_valid (req1_valid),
    .req1_write (req1_write),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata),
    .resp1_err  (resp1_err),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .busy       (busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transfer from a single requester. ready_at is the ACCESS
  // cycle (1-based) on which PREADY is driven high; 0 means never.
  task automatic do_xfer(input string name, input int who, input logic wr,
                         input logic [3:0] a, input logic [7:0] wd,
                         input int ready_at, input logic [7:0] rd,
                         input int exp_acc, input logic exp_err,
                         input logic [7:0] exp_rdata);
    int acc;
    @(negedge PCLK);
    if (who == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = wd;
    end
    PREADY = 1'b1;
    #1;
    check({name, " ready0"}, 32'(req0_ready), 32'(who == 0));
    check({name, " ready1"}, 32'(req1_ready), 32'(who == 1));
    // SETUP cycle; PREADY stays high to show it is ignored here.
    @(negedge PCLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({name, " setup psel"},    32'(PSELx),   32'd1);
    check({name, " setup penable"}, 32'(PENABLE), 32'd0);
    check({name, " setup paddr"},   32'(PADDR),   32'(a));
    check({name, " setup pwrite"},  32'(PWRITE),  32'(wr));
    check({name, " setup pwdata"},  32'(PWDATA),  32'(wd));
    PRDATA = rd;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (!PENABLE) break;
      acc++;
      PREADY = (acc == ready_at);
    end
    PREADY = 1'b0;
    check({name, " access cycles"}, 32'(acc),         32'(exp_acc));
    check({name, " psel after"},    32'(PSELx),       32'd0);
    check({name, " paddr held"},    32'(PADDR),       32'(a));
    check({name, " resp0_valid"},   32'(resp0_valid), 32'(who == 0));
    check({name, " resp1_valid"},   32'(resp1_valid), 32'(who == 1));
    if (who == 0) begin
      check({name, " rdata"}, 32'(resp0_rdata), 32'(exp_rdata));
      check({name, " err"},   32'(resp0_err),   32'(exp_err));
    end else begin
      check({name, " rdata"}, 32'(resp1_rdata), 32'(exp_rdata));
      check({name, " err"},   32'(resp1_err),   32'(exp_err));
    end
    @(negedge PCLK);
    check({name, " resp pulse end"}, 32'(resp0_valid | resp1_valid), 32'd0);
  endtask

  initial begin
    PRESETn = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;

    // Reset values.
    repeat (2) @(negedge PCLK);
    check("rst psel",    32'(PSELx),       32'd0);
    check("rst penable", 32'(PENABLE),     32'd0);
    check("rst busy",    32'(busy),        32'd0);
    check("rst paddr",   32'(PADDR),       32'd0);
    check("rst resp0",   32'(resp0_valid), 32'd0);
    check("rst resp1",   32'(resp1_valid), 32'd0);
    PRESETn = 1'b1;

    // Zero-wait write from req0 (PREADY effectively tied high).
    do_xfer("t1 wr", 0, 1'b1, 4'h3, 8'hA5, 1, 8'h00, 1, 1'b0, 8'h00);
    // Read from req1 with three wait cycles.
    do_xfer("t2 rd", 1, 1'b0, 4'h3, 8'h00, 4, 8'h5A, 4, 1'b0, 8'h5A);

    // Both requesters held valid: grants alternate 0,1,0,1 with no gap.
    @(negedge PCLK);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h1; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'h2; req1_wdata = 8'h22;
    PREADY = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("rr ready0", 32'(req0_ready), 32'(t % 2 == 0));
      check("rr ready1", 32'(req1_ready), 32'(t % 2 == 1));
      if (t > 0) begin
        check("rr resp0 same cycle", 32'(resp0_valid), 32'(t % 2 == 1));
        check("rr resp1 same cycle", 32'(resp1_valid), 32'(t % 2 == 0));
      end
      @(negedge PCLK);
      check("rr setup penable", 32'(PENABLE), 32'd0);
      check("rr setup paddr",   32'(PADDR),   32'((t % 2 == 0) ? 1 : 2));
      @(negedge PCLK);
      check("rr access penable", 32'(PENABLE), 32'd1);
      @(negedge PCLK);
    end
    check("rr last resp1", 32'(resp1_valid), 32'd1);
    check("rr last busy",  32'(busy),        32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge PCLK);
    check("rr stop busy", 32'(busy), 32'd0);

    // Timeouts: first leave nonzero rdata, then abort, then last-cycle success.
    do_xfer("t4 pre", 0, 1'b0, 4'h7, 8'h00, 1,  8'hC3, 1,  1'b0, 8'hC3);
    do_xfer("t4 to",  0, 1'b0, 4'h7, 8'h00, 0,  8'hEE, 16, 1'b1, 8'h00);
    do_xfer("t4 lst", 0, 1'b0, 4'h7, 8'h00, 16, 8'h77, 16, 1'b0, 8'h77);

    // Reset in the middle of ACCESS.
    @(negedge PCLK);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h9; req0_wdata = 8'h99;
    #1;
    check("rst5 ready0", 32'(req0_ready), 32'd1);
    @(negedge PCLK);
    req0_valid = 1'b0;
    PREADY = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst5 in access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("rst5 psel",    32'(PSELx),       32'd0);
    check("rst5 penable", 32'(PENABLE),     32'd0);
    check("rst5 busy",    32'(busy),        32'd0);
    check("rst5 paddr",   32'(PADDR),       32'd0);
    check("rst5 pwrite",  32'(PWRITE),      32'd0);
    check("rst5 pwdata",  32'(PWDATA),      32'd0);
    check("rst5 resp0",   32'(resp0_valid), 32'd0);
    check("rst5 rdata0",  32'(resp0_rdata), 32'd0);
    check("rst5 err0",    32'(resp0_err),   32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst5 no resp0", 32'(resp0_valid), 32'd0);
    check("rst5 no resp1", 32'(resp1_valid), 32'd0);
    // Both valid after reset: req0 must be favoured.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'h5; req0_wdata = 8'h5F;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'h6;
    PREADY = 1'b1;
    #1;
    check("post ready0", 32'(req0_ready), 32'd1);
    check("post ready1", 32'(req1_ready), 32'd0);
    @(negedge PCLK);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("post paddr", 32'(PADDR), 32'h5);
    @(negedge PCLK);
    check("post penable", 32'(PENABLE), 32'd1);
    @(negedge PCLK);
    PREADY = 1'b0;
    check("post resp0", 32'(resp0_valid), 32'd1);
    check("post resp1", 32'(resp1_valid), 32'd0);
    check("post err0",  32'(resp0_err),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master with a round-robin arbiter. It sequences shared accesses to the 8-bit/4-bit-address APB register slave on the UART subsystem bus.
- Requesters are the host-side register port (req0) and the UART bridge (req1). Each presents a single read or write command.
- The block runs IDLE→SETUP→ACCESS on the bus, waits on PREADY with a timeout, then returns read data or an error to the owning requester.

Parameters:
- TIMEOUT, 16: maximum ACCESS-phase cycles without PREADY before the transfer aborts with error. Legal range 2..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 command valid; hold with fields stable until accepted
- req0_write  in  1  1=write, 0=read
- req0_addr  in  4  register address
- req0_wdata  in  8  write data
- req0_ready  out  1  combinational accept; handshake = valid&ready at rising edge
- resp0_valid  out  1  one-cycle response pulse
- resp0_rdata  out  8  read data, valid with resp0_valid
- resp0_err  out  1  timeout error, valid with resp0_valid
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata, resp1_err: same as requester 0, for requester 1
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  4  APB address
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- PREADY  in  1  APB transfer complete
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock (PCLK). Reset is synchronous and active-low (PRESETn), sampled on the PCLK rising edge.
- Reset values: all outputs are 0. State is IDLE, the round-robin pointer favours req0, the wait counter is 0 and the latched command is cleared.
- Reset during SETUP or ACCESS: the bus drops to PSELx=PENABLE=0 on that edge. The in-flight transfer is discarded and no resp is issued.
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - PSELx=PENABLE=0.
  - reqN_ready is 1 only for the arbitration winner, and only while its reqN_valid=1. The loser's ready is 0.
  - On handshake: latch write/addr/wdata into PWRITE/PADDR/PWDATA, record the owner, go to SETUP.
- Arbitration:
  - One valid request: it wins.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates only on handshake.
- SETUP: PSELx=1, PENABLE=0 for exactly one cycle. PREADY is ignored. Go to ACCESS, wait counter = 0.
- ACCESS:
  - PSELx=1, PENABLE=1. PADDR, PWRITE and PWDATA stay stable for the whole transfer.
  - PREADY=1 at an edge: transfer succeeds. For a read, capture PRDATA into respN_rdata. For a write, respN_rdata = 0. Set respN_err=0, go to IDLE.
  - PREADY=0: increment the counter. If the counter reaches TIMEOUT-1 while PREADY=0, abort: respN_err=1, respN_rdata=0, go to IDLE.
  - PREADY=1 on the final allowed cycle counts as success, not error.
- Response timing:
  - respN_valid is registered and high for exactly the one cycle after the completing edge, which is the first IDLE cycle.
  - Only the owner's resp pulses. rdata and err hold their values until the next response to that requester.
- Latency and throughput:
  - Minimum handshake-to-resp_valid latency is 3 cycles: handshake edge → SETUP → ACCESS with PREADY=1 → resp.
  - A new request can be accepted in the same IDLE cycle as the previous resp_valid, so zero-wait back-to-back throughput is one transfer per 3 cycles.
- Bus outputs leaving ACCESS: PSELx and PENABLE go to 0 on the completing edge. PADDR, PWRITE and PWDATA hold their last values.
- Protocol errors: reqN_valid dropping before handshake is a requester protocol error. Behaviour is unspecified and must not hang the FSM.

Test Plan:
- Reset, then req0 write addr=4'h3 data=8'hA5 with PREADY tied 1 → req0_ready high the same cycle. PSELx=1/PENABLE=0 for 1 cycle, then PSELx=PENABLE=1 for 1 cycle with PADDR=3, PWDATA=A5, PWRITE=1. resp0_valid pulses once, resp0_err=0. resp1_valid never asserts.
- req1 read addr=4'h3, slave returns PRDATA=8'h5A after 3 wait cycles (PREADY=1 on the 4th ACCESS cycle) → ACCESS lasts 4 cycles, resp1_rdata=8'h5A, resp1_err=0.
- req0 and req1 both held valid continuously for 4 transfers, PREADY=1 → grants go 0,1,0,1. Each transfer takes 3 cycles, with no idle cycle between resp_valid and the next SETUP.
- PREADY held 0, TIMEOUT=16 → exactly 16 ACCESS cycles, then resp0_valid with resp0_err=1, resp0_rdata=0. Repeat with PREADY=1 on ACCESS cycle 16 → resp0_err=0.
- PRESETn low for 1 cycle during ACCESS → all outputs 0 on the next cycle and no resp pulse. The next request completes normally with req0 favoured.
